// File: rtl/csr_counter_file.sv
// csr_counter_file: 64-bit cycle/time/instret/hpm counters with mcountinhibit, mcounteren and a registered CSR read-modify-write port.
module csr_counter_file #(
  parameter int XLEN     = 32,
  parameter int NUM_HPM  = 4,
  parameter int TIME_DIV = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [1:0]         priv_mode,
  input  logic               instr_retired,
  input  logic [NUM_HPM-1:0] hpm_event,
  input  logic               csr_valid,
  input  logic [1:0]         csr_op,
  input  logic               csr_write_en,
  input  logic [11:0]        csr_addr,
  input  logic [XLEN-1:0]    csr_wdata,
  output logic               resp_valid,
  output logic [XLEN-1:0]    csr_rdata,
  output logic               illegal_instr_exception
);
  localparam int NC = 3 + NUM_HPM;
  localparam int PW = TIME_DIV > 1 ? $clog2(TIME_DIV) : 1;
  logic [63:0] cnt [NC];
  logic [NC-1:0] inhibit, counteren, events;
  logic [PW-1:0] presc;
  logic [31:0] en_ext;
  logic [4:0] idx;
  logic [63:0] cnt_sel;
  logic [XLEN-1:0] old_val, new_val;
  logic tick, is_m, sec_c, sec_b, hi, cnt_addr, mapped, illegal, do_write;
  assign tick = presc == PW'(TIME_DIV - 1);
  assign events = {hpm_event, instr_retired, tick, 1'b1};
  assign is_m = priv_mode == 2'b11;
  assign idx = csr_addr[4:0];
  assign hi = csr_addr[7];
  assign sec_c = csr_addr[11:8] == 4'hC;
  assign sec_b = csr_addr[11:8] == 4'hB;
  assign en_ext = 32'(counteren);
  // mtime has no machine-writable alias, so B01/B81 stay unmapped
  assign cnt_addr = (sec_c || sec_b) && csr_addr[6:5] == 2'b00 && {1'b0, idx} < 6'(NC) && !(sec_b && idx == 5'd1);
  assign mapped = cnt_addr || csr_addr == 12'h320 || csr_addr == 12'h306;
  assign illegal = !mapped || csr_op == 2'b00 || ((sec_b || csr_addr[11:8] == 4'h3) && !is_m) ||
                   (sec_c && !is_m && !en_ext[idx]) || (sec_c && csr_write_en);
  assign do_write = csr_valid && !illegal && csr_write_en;
  always_comb begin
    cnt_sel = '0;
    for (int k = 0; k < NC; k++) cnt_sel = idx == 5'(k) ? cnt[k] : cnt_sel;
    old_val = cnt_addr ? (hi ? cnt_sel[63:32] : cnt_sel[31:0]) :
              csr_addr == 12'h320 ? XLEN'(inhibit) :
              csr_addr == 12'h306 ? XLEN'(counteren) : '0;
    new_val = csr_op == 2'b01 ? csr_wdata : csr_op == 2'b10 ? (old_val | csr_wdata) : (old_val & ~csr_wdata);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      presc <= '0;
      inhibit <= '0;
      counteren <= '0;
      resp_valid <= 1'b0;
      csr_rdata <= '0;
      illegal_instr_exception <= 1'b0;
      for (int k = 0; k < NC; k++) cnt[k] <= '0;
    end else begin
      presc <= tick ? '0 : presc + PW'(1);
      // a written counter skips its increment and its other half holds
      for (int k = 0; k < NC; k++)
        if (do_write && sec_b && idx == 5'(k)) begin
          if (hi) cnt[k][63:32] <= new_val;
          else cnt[k][31:0] <= new_val;
        end else if (events[k] && !inhibit[k]) cnt[k] <= cnt[k] + 64'd1;
      if (do_write && csr_addr == 12'h320) inhibit <= new_val[NC-1:0] & ~NC'(2);
      if (do_write && csr_addr == 12'h306) counteren <= new_val[NC-1:0];
      resp_valid <= csr_valid;
      csr_rdata <= csr_valid && !illegal ? old_val : '0;
      illegal_instr_exception <= csr_valid && illegal;
    end
  end
endmodule

// File: tb/tb_csr_counter_file.sv
// tb_csr_counter_file: table vectors plus hand sequences, responses checked through a one-deep scoreboard queue.
module tb_csr_counter_file;
  logic clock = 0, reset;
  logic [1:0] priv_mode, csr_op;
  logic instr_retired, csr_valid, csr_write_en;
  logic [3:0] hpm_event;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata, csr_rdata;
  logic resp_valid, illegal_instr_exception;
  csr_counter_file #(.XLEN(32), .NUM_HPM(4), .TIME_DIV(4)) dut (
    .clock(clock), .reset(reset), .priv_mode(priv_mode), .instr_retired(instr_retired),
    .hpm_event(hpm_event), .csr_valid(csr_valid), .csr_op(csr_op), .csr_write_en(csr_write_en),
    .csr_addr(csr_addr), .csr_wdata(csr_wdata), .resp_valid(resp_valid), .csr_rdata(csr_rdata),
    .illegal_instr_exception(illegal_instr_exception));
  always #5 clock = ~clock;
  typedef struct { logic v; logic [31:0] rd; logic ill; string nm; } exp_t;
  typedef struct { logic [1:0] pr; logic [1:0] op; logic we; logic [11:0] a; logic [31:0] wd; logic [31:0] erd; logic eill; string nm; } vec_t;
  exp_t sb[$];
  vec_t tbl[14];
  int total = 0, bad = 0;
  logic [63:0] m_cyc = 0, m_time = 0, m_ret = 0, m_hpm = 0;
  logic [31:0] m_inh = 0, v1, t1;
  int m_pre = 0;
  function automatic void chk(string nm, string f, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s %s: got %h want %h", nm, f, act, exp);
    end
  endfunction
  function automatic logic [31:0] mr(logic [11:0] a);
    case (a)
      12'hC00, 12'hB00: return m_cyc[31:0];
      12'hC80, 12'hB80: return m_cyc[63:32];
      12'hC01: return m_time[31:0];
      12'hC81: return m_time[63:32];
      12'hC02, 12'hB02: return m_ret[31:0];
      12'hC82, 12'hB82: return m_ret[63:32];
      12'hC03, 12'hB03: return m_hpm[31:0];
      12'hC83, 12'hB83: return m_hpm[63:32];
      12'h320: return m_inh;
      default: return 32'd0;
    endcase
  endfunction
  task automatic check_pop();
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard", "empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    chk(e.nm, "valid", 32'(resp_valid), 32'(e.v));
    chk(e.nm, "rdata", csr_rdata, e.rd);
    chk(e.nm, "illegal", 32'(illegal_instr_exception), 32'(e.ill));
  endtask
  task automatic drive(input logic v, input logic [1:0] pr, input logic [1:0] op, input logic we,
                       input logic [11:0] a, input logic [31:0] wd, input logic [31:0] erd,
                       input logic eill, input string nm);
    logic [31:0] nv;
    logic wc, wr, wh;
    csr_valid = v; priv_mode = pr; csr_op = op; csr_write_en = we; csr_addr = a; csr_wdata = wd;
    sb.push_back('{v, (v && !eill) ? erd : 32'd0, v && eill, nm});
    @(posedge clock); #1;
    nv = op == 2'b01 ? wd : op == 2'b10 ? (erd | wd) : (erd & ~wd);
    wc = 0; wr = 0; wh = 0;
    if (v && !eill && we) begin
      wc = a == 12'hB00 || a == 12'hB80;
      wr = a == 12'hB02 || a == 12'hB82;
      wh = a == 12'hB03 || a == 12'hB83;
    end
    if (!wc && !m_inh[0]) m_cyc++;
    if (m_pre == 3) begin m_pre = 0; m_time++; end else m_pre++;
    if (!wr && instr_retired && !m_inh[2]) m_ret++;
    if (!wh && hpm_event[0] && !m_inh[3]) m_hpm++;
    if (wc) begin if (a[7]) m_cyc[63:32] = nv; else m_cyc[31:0] = nv; end
    if (wr) begin if (a[7]) m_ret[63:32] = nv; else m_ret[31:0] = nv; end
    if (wh) begin if (a[7]) m_hpm[63:32] = nv; else m_hpm[31:0] = nv; end
    if (v && !eill && we && a == 12'h320) m_inh = nv & 32'h7D;
    check_pop();
  endtask
  task automatic idle();
    drive(0, 2'b00, 2'b00, 0, 12'h000, 32'd0, 32'd0, 0, "idle");
  endtask
  initial begin
    reset = 1; priv_mode = 0; csr_op = 0; csr_write_en = 0; csr_addr = 0; csr_wdata = 0;
    csr_valid = 0; instr_retired = 0; hpm_event = 0;
    repeat (2) @(posedge clock);
    #1;
    csr_valid = 1; priv_mode = 2'b11; csr_op = 2'b01; csr_write_en = 1; csr_addr = 12'hB00; csr_wdata = 32'h1234;
    sb.push_back('{1'b0, 32'd0, 1'b0, "reset_drop"});
    @(posedge clock); #1;
    reset = 0;
    check_pop();
    repeat (10) idle();
    drive(1, 2'b11, 2'b10, 0, 12'hC00, 0, 32'd10, 0, "cycle_after_idle");
    tbl[0]  = '{2'b00, 2'b10, 0, 12'hC02, 32'd0, 32'd0, 1, "u_instret_noen"};
    tbl[1]  = '{2'b11, 2'b00, 0, 12'h306, 32'd0, 32'd0, 1, "op_reserved"};
    tbl[2]  = '{2'b11, 2'b01, 1, 12'hC01, 32'd0, 32'd0, 1, "wr_time_ro"};
    tbl[3]  = '{2'b11, 2'b01, 1, 12'h7C0, 32'd0, 32'd0, 1, "unmapped_7c0"};
    tbl[4]  = '{2'b00, 2'b10, 0, 12'h320, 32'd0, 32'd0, 1, "u_inhibit"};
    tbl[5]  = '{2'b00, 2'b10, 0, 12'hB00, 32'd0, 32'd0, 1, "u_mcycle"};
    tbl[6]  = '{2'b11, 2'b10, 0, 12'hB01, 32'd0, 32'd0, 1, "no_mtime"};
    tbl[7]  = '{2'b11, 2'b10, 0, 12'hC07, 32'd0, 32'd0, 1, "hpm_oob"};
    tbl[8]  = '{2'b11, 2'b01, 1, 12'h306, 32'hFFFF_FFFF, 32'd0, 0, "en_rw"};
    tbl[9]  = '{2'b11, 2'b10, 0, 12'h306, 32'd0, 32'h7F, 0, "en_mask"};
    tbl[10] = '{2'b11, 2'b11, 1, 12'h306, 32'hFFFF_FFFB, 32'h7F, 0, "en_rc"};
    tbl[11] = '{2'b11, 2'b10, 0, 12'h306, 32'd0, 32'h04, 0, "en_after_rc"};
    tbl[12] = '{2'b01, 2'b10, 0, 12'h306, 32'd0, 32'd0, 1, "priv01_is_u"};
    tbl[13] = '{2'b11, 2'b10, 0, 12'hC20, 32'd0, 32'd0, 1, "gap_c20"};
    for (int i = 0; i < 14; i++)
      drive(1, tbl[i].pr, tbl[i].op, tbl[i].we, tbl[i].a, tbl[i].wd, tbl[i].erd, tbl[i].eill, tbl[i].nm);
    instr_retired = 1;
    repeat (3) idle();
    instr_retired = 0;
    drive(1, 2'b00, 2'b10, 0, 12'hC02, 0, 32'd3, 0, "u_instret_en");
    drive(1, 2'b00, 2'b10, 0, 12'hC00, 0, 32'd0, 1, "u_cycle_noen");
    drive(1, 2'b11, 2'b01, 1, 12'hB00, 32'hFFFF_FFFF, mr(12'hB00), 0, "wr_mcycle");
    idle();
    drive(1, 2'b11, 2'b10, 0, 12'hC80, 0, 32'd1, 0, "cycle_carry");
    drive(1, 2'b11, 2'b10, 0, 12'hC00, 0, mr(12'hC00), 0, "cycle_lo");
    drive(1, 2'b11, 2'b10, 1, 12'h320, 32'd7, 32'd0, 0, "inh_set");
    v1 = mr(12'hC00);
    instr_retired = 1;
    drive(1, 2'b11, 2'b10, 0, 12'hC00, 0, v1, 0, "inh_frozen_a");
    repeat (5) idle();
    instr_retired = 0;
    drive(1, 2'b11, 2'b10, 0, 12'hC00, 0, v1, 0, "inh_frozen_b");
    drive(1, 2'b11, 2'b10, 0, 12'h320, 0, 32'd5, 0, "inh_bit1_zero");
    drive(1, 2'b11, 2'b11, 1, 12'h320, 0, 32'd5, 0, "rc_zero");
    drive(1, 2'b11, 2'b10, 0, 12'h320, 0, 32'd5, 0, "rc_zero_keep");
    drive(1, 2'b11, 2'b11, 1, 12'h320, 32'd5, 32'd5, 0, "inh_clear");
    drive(1, 2'b11, 2'b10, 0, 12'hC00, 0, v1, 0, "inh_clear_timing");
    drive(1, 2'b11, 2'b10, 0, 12'hC00, 0, v1 + 32'd1, 0, "cycle_resume");
    drive(1, 2'b11, 2'b10, 0, 12'hB02, 0, 32'd3, 0, "instret_inhibited");
    t1 = mr(12'hC01);
    drive(1, 2'b11, 2'b10, 0, 12'hC01, 0, t1, 0, "time_a");
    repeat (3) idle();
    drive(1, 2'b11, 2'b10, 0, 12'hC01, 0, t1 + 32'd1, 0, "time_div4");
    hpm_event = 4'b0001;
    drive(1, 2'b11, 2'b01, 1, 12'hB03, 32'd100, mr(12'hB03), 0, "hpm_wr");
    hpm_event = 0;
    drive(1, 2'b11, 2'b10, 0, 12'hB03, 0, 32'd100, 0, "hpm_no_inc");
    hpm_event = 4'b0001;
    repeat (2) idle();
    hpm_event = 0;
    drive(1, 2'b11, 2'b10, 0, 12'hC03, 0, 32'd102, 0, "hpm_count");
    drive(1, 2'b11, 2'b10, 0, 12'hC83, 0, 32'd0, 0, "hpm_hi");
    drive(1, 2'b11, 2'b01, 1, 12'hB02, 32'h55, 32'd3, 0, "wr_minstret");
    drive(1, 2'b11, 2'b10, 0, 12'hB02, 0, 32'h55, 0, "b2b_read");
    drive(1, 2'b11, 2'b10, 1, 12'hB82, 32'd1, 32'd0, 0, "rs_hi");
    drive(1, 2'b11, 2'b10, 0, 12'hC82, 0, 32'd1, 0, "hi_read");
    drive(1, 2'b11, 2'b10, 0, 12'hC02, 0, 32'h55, 0, "lo_kept");
    idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
